pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8: bits added per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.
REQ-003 Ports SHALL be:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block accepts input this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_cin  in  1  carry-in; ignored when i_sub=1.
- i_sub  in  1  0 = A+B+cin, 1 = A-B.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_sum  out  WIDTH  result, modulo 2^WIDTH.
- o_cout  out  1  carry-out of MSB; for subtract, 1 = no borrow.
- o_ovf  out  1  two's-complement signed overflow.

Function
REQ-004 The pipeline SHALL have STAGES registered stages; stage k adds chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) using carry from stage k-1, registered.
REQ-005 Stage 0 SHALL use carry-in = i_sub ? 1 : i_cin and operand B = i_sub ? ~i_b : i_b.
REQ-006 Unprocessed upper operand chunks and completed lower sum chunks SHALL travel with their token through every stage.
REQ-007 Advance condition adv = i_ready | ~o_valid; all stages SHALL shift by one exactly when adv=1 and hold otherwise.
REQ-008 o_ready SHALL equal adv, combinationally.
REQ-009 Transfer in SHALL occur on a rising edge with i_valid & o_ready; transfer out on o_valid & i_ready.
REQ-010 Latency SHALL be exactly STAGES cycles from accept to o_valid with no stall; throughput one result per cycle.
REQ-011 A stage with no token SHALL carry valid=0; bubbles SHALL propagate and SHALL NOT be squeezed out while adv=0.
REQ-012 o_sum, o_cout and o_ovf SHALL remain stable while o_valid=1 and i_ready=0.
REQ-013 o_ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB for the effective operation.
REQ-014 Inputs when i_valid=0 SHALL NOT alter any valid token.
REQ-015 Simultaneous accept and emit in one cycle SHALL both occur with no lost or duplicated token.

Reset
REQ-016 i_rst_n=0 SHALL asynchronously clear all stage valid bits; o_valid=0, o_sum=0, o_cout=0, o_ovf=0.
REQ-017 In-flight tokens SHALL be discarded on reset mid-operation; o_ready SHALL be 1 during and after reset.
REQ-018 Reset deassertion SHALL be synchronised externally; the block takes the first transfer on the first edge with i_rst_n=1.

Structure
REQ-019 Package adder_pkg SHALL hold default WIDTH and CHUNK constants and the STAGES derivation function.
REQ-020 One sub-module adder_stage (CHUNK-bit registered add with carry in/out and valid) SHALL be instantiated STAGES times via generate.
REQ-021 The block SHALL contain no combinational path from i_a/i_b to any output.

Verification (WIDTH=32, CHUNK=8)
REQ-022 Accept A=0xFFFFFFFF, B=0x1, cin=0, i_ready=1 -> exactly 4 cycles later: o_sum=0, o_cout=1, o_ovf=0.
REQ-023 A=0x7FFFFFFF, B=0x1, add -> o_sum=0x80000000, o_ovf=1, o_cout=0; then A=5, B=7, i_sub=1 -> o_sum=0xFFFFFFFE, o_cout=0, o_ovf=0.
REQ-024 Hold i_ready=0 with 4 tokens in flight -> o_ready=0, o_valid=1 and o_sum stable; release -> all 4 results emitted in order, one per cycle.
REQ-025 Stream 1000 random back-to-back pairs with random i_ready and i_sub -> every result matches the reference model in order, none lost or duplicated.
REQ-026 Pull i_rst_n low with 3 tokens in flight -> o_valid=0 immediately; after release no stale result appears.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CHUNK = 8;

    // Number of chunk stages; never less than one even for degenerate parameters.
    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
        int unsigned n;
        n = (chunk == 0) ? 1 : width / chunk;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the adder: adds its operand chunk plus incoming carry
// and registers sum, carry-out and the token valid bit when the pipeline advances.
module adder_stage
#(
    parameter int unsigned CHUNK = 8
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic             valid_o,
    output logic [CHUNK-1:0] sum_o,
    output logic             c_o
);

    logic [CHUNK:0]   full_d;
    logic             valid_q;
    logic [CHUNK-1:0] sum_q;
    logic             c_q;

    assign full_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            c_q     <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= full_d[CHUNK-1:0];
            c_q     <= full_d[CHUNK];
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign c_o     = c_q;

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: one CHUNK-bit slice per stage, with the
// untouched upper operand bits and finished lower sum bits travelling alongside.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);
    localparam int unsigned LAST   = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The whole pipe moves as one; a stalled head freezes every stage, bubbles included.
    assign adv     = i_ready | ~o_valid;
    assign o_ready = adv;
    assign b_eff   = i_sub ? ~i_b : i_b;
    assign cin_eff = i_sub | i_cin;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [CHUNK-1:0] a_chunk;
        logic [CHUNK-1:0] b_chunk;
        logic             stage_valid;
        logic [CHUNK-1:0] stage_sum;
        logic             stage_carry;

        if (gi == 0) begin : g_in
            assign v_in    = i_valid;
            assign c_in    = cin_eff;
            assign a_chunk = i_a[CHUNK-1:0];
            assign b_chunk = b_eff[CHUNK-1:0];
        end else begin : g_in
            assign v_in    = g_stage[gi-1].stage_valid;
            assign c_in    = g_stage[gi-1].stage_carry;
            assign a_chunk = g_stage[gi-1].g_rem.a_rem_q[CHUNK-1:0];
            assign b_chunk = g_stage[gi-1].g_rem.b_rem_q[CHUNK-1:0];
        end

        adder_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk_i   (i_clk),
            .rst_ni  (i_rst_n),
            .en_i    (adv),
            .valid_i (v_in),
            .a_i     (a_chunk),
            .b_i     (b_chunk),
            .c_i     (c_in),
            .valid_o (stage_valid),
            .sum_o   (stage_sum),
            .c_o     (stage_carry)
        );

        // Operand bits not yet consumed; the next stage eats the low chunk of these.
        if (gi < LAST) begin : g_rem
            localparam int unsigned REM = WIDTH - (gi + 1) * CHUNK;
            logic [REM-1:0] a_rem_d;
            logic [REM-1:0] b_rem_d;
            logic [REM-1:0] a_rem_q;
            logic [REM-1:0] b_rem_q;

            if (gi == 0) begin : g_src
                assign a_rem_d = i_a[WIDTH-1:CHUNK];
                assign b_rem_d = b_eff[WIDTH-1:CHUNK];
            end else begin : g_src
                assign a_rem_d = g_stage[gi-1].g_rem.a_rem_q[REM+CHUNK-1:CHUNK];
                assign b_rem_d = g_stage[gi-1].g_rem.b_rem_q[REM+CHUNK-1:CHUNK];
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (adv) begin
                    a_rem_q <= a_rem_d;
                    b_rem_q <= b_rem_d;
                end
            end
        end

        // Sum chunks already finished by earlier stages.
        if (gi > 0) begin : g_done
            logic [gi*CHUNK-1:0] done_d;
            logic [gi*CHUNK-1:0] done_q;

            if (gi == 1) begin : g_src
                assign done_d = g_stage[0].stage_sum;
            end else begin : g_src
                assign done_d = {g_stage[gi-1].stage_sum, g_stage[gi-1].g_done.done_q};
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    done_q <= '0;
                end else if (adv) begin
                    done_q <= done_d;
                end
            end
        end

        // a^b at the MSB lets the carry into the MSB be recovered from the registered sum bit.
        if (gi == LAST) begin : g_ovf
            logic msb_x_d;
            logic msb_x_q;

            assign msb_x_d = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    msb_x_q <= 1'b0;
                end else if (adv) begin
                    msb_x_q <= msb_x_d;
                end
            end
        end
    end

    if (STAGES == 1) begin : g_out
        assign o_sum = g_stage[0].stage_sum;
    end else begin : g_out
        assign o_sum = {g_stage[LAST].stage_sum, g_stage[LAST].g_done.done_q};
    end

    assign o_valid = g_stage[LAST].stage_valid;
    assign o_cout  = g_stage[LAST].stage_carry;
    assign o_ovf   = g_stage[LAST].g_ovf.msb_x_q
                   ^ g_stage[LAST].stage_sum[CHUNK-1]
                   ^ g_stage[LAST].stage_carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, CHUNK=8): directed corner cases,
// stall/backpressure, a random stream and mid-flight reset.
module tb_pipelined_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_cin;
    logic        i_sub;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum;
    logic        o_cout;
    logic        o_ovf;

    res_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   n_out  = 0;
    logic in_fire, out_fire, obs_valid, obs_ready, obs_iready;
    res_t obs;

    pipelined_adder #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_cin   (i_cin),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Reference: signed overflow taken from operand/result signs, not from carries.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [31:0] bb;
        logic        c0;
        logic [32:0] full;
        bb     = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        return r;
    endfunction

    // Samples handshakes at the falling edge, records accepted operands, then steps one cycle.
    task automatic tick();
        @(negedge i_clk);
        in_fire    = i_valid && o_ready;
        out_fire   = o_valid && i_ready;
        obs_valid  = o_valid;
        obs_ready  = o_ready;
        obs_iready = i_ready;
        obs        = {o_sum, o_cout, o_ovf};
        if (in_fire) sb.push_back(model(i_a, i_b, i_cin, i_sub));
        if (out_fire) begin
            n_out++;
            $display("out %0d: sum=%08h cout=%b ovf=%b", n_out, o_sum, o_cout, o_ovf);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b1;
        i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else passed++;
        checks++; if (o_sum !== 32'h0) $display("FAIL reset_sum: got %h want 0", o_sum); else passed++;
        checks++; if ({o_cout, o_ovf} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {o_cout, o_ovf}); else passed++;
        checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_ready); else passed++;
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if ({o_ready, o_valid} !== 2'b10) $display("FAIL reset_hold: got ready,valid=%b want 10", {o_ready, o_valid}); else passed++;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_carry();
        int   lat;
        bit   found;
        res_t got;
        lat = 0; found = 0; got = '0;
        i_ready = 1'b1; i_valid = 1'b1; i_a = 32'hFFFF_FFFF; i_b = 32'h1; i_cin = 1'b0; i_sub = 1'b0;
        tick();
        checks++; if (in_fire !== 1'b1) $display("FAIL carry_accept: got %b want 1", in_fire); else passed++;
        i_valid = 1'b0; i_a = $urandom; i_b = $urandom;
        for (int k = 1; k <= 10 && !found; k++) begin
            tick();
            if (out_fire) begin found = 1; lat = k; got = obs; end
        end
        checks++; if (lat != 4) $display("FAIL carry_latency: got %0d want 4", lat); else passed++;
        checks++; if (got !== {32'h0, 1'b1, 1'b0}) $display("FAIL carry_result: got %h want %h", got, {32'h0, 1'b1, 1'b0}); else passed++;
        sb.delete();
    endtask

    task automatic test_overflow();
        res_t r[2];
        int   n, acc;
        n = 0; acc = 0;
        i_ready = 1'b1;
        i_valid = 1'b1; i_a = 32'h7FFF_FFFF; i_b = 32'h1; i_cin = 1'b0; i_sub = 1'b0;
        tick(); if (in_fire) acc++;
        i_a = 32'd5; i_b = 32'd7; i_cin = 1'b1; i_sub = 1'b1;
        tick(); if (in_fire) acc++;
        i_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_fire) begin
                if (n < 2) r[n] = obs;
                n++;
            end
        end
        checks++; if (acc != 2 || n != 2) $display("FAIL ovf_count: got in=%0d out=%0d want 2/2", acc, n); else passed++;
        checks++; if (r[0] !== {32'h8000_0000, 1'b0, 1'b1}) $display("FAIL ovf_add: got %h want %h", r[0], {32'h8000_0000, 1'b0, 1'b1}); else passed++;
        checks++; if (r[1] !== {32'hFFFF_FFFE, 1'b0, 1'b0}) $display("FAIL ovf_sub: got %h want %h", r[1], {32'hFFFF_FFFE, 1'b0, 1'b0}); else passed++;
        sb.delete();
    endtask

    task automatic test_stall();
        int   sent, n, stall_bad;
        res_t held, exp;
        sent = 0; n = 0; stall_bad = 0;
        i_ready = 1'b0;
        for (int k = 0; k < 20 && sent < 4; k++) begin
            i_valid = 1'b1; i_a = $urandom; i_b = $urandom; i_cin = k[0]; i_sub = k[1];
            tick();
            if (in_fire) sent++;
        end
        checks++; if (sent != 4) $display("FAIL stall_fill: got %0d accepted want 4", sent); else passed++;
        held = (sb.size() != 0) ? sb[0] : '0;
        i_a = $urandom; i_b = $urandom;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs !== held) stall_bad++;
        end
        checks++; if (stall_bad != 0) $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); else passed++;
        i_valid = 1'b0; i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_fire) begin
                n++;
                exp = (sb.size() != 0) ? sb.pop_front() : '0;
                checks++; if (obs !== exp) $display("FAIL stall_drain%0d: got %h want %h", k, obs, exp); else passed++;
            end
        end
        checks++; if (n != 4 || sb.size() != 0) $display("FAIL stall_count: got %0d consecutive want 4", n); else passed++;
        sb.delete();
    endtask

    task automatic test_back_to_back();
        int   sent, got, stable_bad, mism;
        bit   prev_hold;
        res_t prev, exp;
        sent = 0; got = 0; stable_bad = 0; mism = 0; prev_hold = 0; prev = '0;
        for (int cyc = 0; cyc < 30000 && got < 1000; cyc++) begin
            i_valid = (sent < 1000) && ($urandom_range(0, 9) < 8);
            i_ready = ($urandom_range(0, 3) != 0);
            i_sub   = $urandom_range(0, 1);
            i_cin   = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       begin i_a = 32'h7FFF_FFFF; i_b = $urandom_range(0, 2); end
                1:       begin i_a = 32'h8000_0000; i_b = $urandom_range(0, 2); end
                2:       begin i_a = 32'hFFFF_FFFF; i_b = $urandom; end
                default: begin i_a = $urandom; i_b = $urandom; end
            endcase
            tick();
            if (in_fire) sent++;
            if (prev_hold && obs_valid && obs !== prev) stable_bad++;
            prev_hold = obs_valid && !obs_iready;
            prev      = obs;
            if (out_fire) begin
                got++;
                if (sb.size() == 0) begin
                    checks++; $display("FAIL b2b_extra: got %h want no output", obs);
                end else begin
                    exp = sb.pop_front();
                    checks++;
                    if (obs !== exp) begin
                        mism++;
                        if (mism <= 10) $display("FAIL b2b_result%0d: got %h want %h", got, obs, exp);
                    end else passed++;
                end
            end
        end
        checks++; if (stable_bad != 0) $display("FAIL b2b_stable: got %0d changes want 0", stable_bad); else passed++;
        checks++; if (got != 1000 || sb.size() != 0) $display("FAIL b2b_count: got %0d out %0d left want 1000/0", got, sb.size()); else passed++;
        i_valid = 1'b0; i_ready = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int   acc, n, lat, early;
        res_t got;
        acc = 0; n = 0; lat = 0; early = 0; got = '0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_a = $urandom; i_b = $urandom; i_cin = 1'b0; i_sub = 1'b0;
            tick();
            if (in_fire) acc++;
        end
        checks++; if (acc != 3) $display("FAIL rmid_fill: got %0d want 3", acc); else passed++;
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if ({o_valid, o_ready} !== 2'b01) $display("FAIL rmid_async: got valid,ready=%b want 01", {o_valid, o_ready}); else passed++;
        sb.delete();
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_fire) early++;
        end
        checks++; if (early != 0) $display("FAIL rmid_stale: got %0d outputs want 0", early); else passed++;
        i_valid = 1'b1; i_a = 32'd3; i_b = 32'd4; i_cin = 1'b0; i_sub = 1'b0;
        tick();
        checks++; if (in_fire !== 1'b1) $display("FAIL rmid_accept: got %b want 1", in_fire); else passed++;
        i_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (out_fire) begin
                n++;
                if (n == 1) begin lat = k; got = obs; end
            end
        end
        checks++; if (n != 1 || lat != 4) $display("FAIL rmid_latency: got %0d outs at %0d want 1 at 4", n, lat); else passed++;
        checks++; if (got !== {32'd7, 1'b0, 1'b0}) $display("FAIL rmid_result: got %h want %h", got, {32'd7, 1'b0, 1'b0}); else passed++;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_carry();
        test_overflow();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
